// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Walks a program counter through block-aligned
// instruction-memory requests (FETCH_WIDTH 32-bit words per block), follows
// predictor redirects and pipeline flushes, and feeds the fetched words through
// a fetch queue to decode one instruction per cycle.
//
// Parameters
//   FETCH_WIDTH  instructions per memory block (power of two, 1..8)
//   FQ_DEPTH     fetch-queue entries (power of two, >= FETCH_WIDTH)
//   RESET_PC     XLEN-wide start address
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   imem_req_valid/ready/addr  block fetch request (addr is block aligned)
//   imem_resp_valid/data       in-order block response, lane i = base+4*i
//   pred_valid, pred_pc        redirect for the request being issued
//   flush, flush_pc            pipeline redirect, highest priority
//   deq_valid/ready/pc/instr   queue head towards decode
//   fq_count                   current queue occupancy
//   dbg_state                  FSM state (0 REQ, 1 WAIT, 2 DROP)
//   perf_starve_cycles         only with FETCH_PERF_CNT_EN defined: saturating
//                              count of cycles decode was ready but starved
//
// Optional feature macro: FETCH_PERF_CNT_EN
//
// Handshakes: every valid/ready pair transfers exactly on a rising edge where
// both are 1. A request, once valid, holds valid and address stable until it
// is accepted; only a flush may change the address while it waits. Responses
// have no ready: one arrives per accepted request, in order.
// -----------------------------------------------------------------------------

package general_defines;
    localparam int XLEN = 32;
endpackage

module fetch_unit
    import general_defines::*;
#(
    parameter int              FETCH_WIDTH = 2,
    parameter int              FQ_DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_resp_valid,
    input  logic [FETCH_WIDTH*32-1:0]   imem_resp_data,
    input  logic                        pred_valid,
    input  logic [XLEN-1:0]             pred_pc,
    input  logic                        flush,
    input  logic [XLEN-1:0]             flush_pc,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output logic [XLEN-1:0]             deq_pc,
    output logic [31:0]                 deq_instr,
    output logic [$clog2(FQ_DEPTH):0]   fq_count,
    output logic [1:0]                  dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_starve_cycles
`endif
);

    localparam int LOG_FW      = $clog2(FETCH_WIDTH);
    localparam int BLOCK_BYTES = FETCH_WIDTH * 4;
    localparam int LANE_W      = LOG_FW + 1;
    localparam int CNT_W       = $clog2(FQ_DEPTH) + 1;
    // A one-entry queue still needs a 1-bit pointer; the occupancy counter
    // keeps the number of live entries within FQ_DEPTH either way.
    localparam int PTR_W       = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int SLOTS       = 1 << PTR_W;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   wait_pc_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [XLEN-1:0]   pc_mem    [SLOTS];
    logic [31:0]       instr_mem [SLOTS];

    logic [XLEN-1:0]   block_mask;
    logic [XLEN-1:0]   req_base;
    logic [XLEN-1:0]   wait_base;
    logic [CNT_W-1:0]  free_cnt;
    logic              req_fire;
    logic              resp_take;
    logic              deq_fire;
    logic [LANE_W-1:0] start_lane;
    logic [CNT_W-1:0]  enq_num;
    logic [FETCH_WIDTH-1:0] lane_en;
    logic [PTR_W-1:0]  lane_slot [FETCH_WIDTH];

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign block_mask     = ~XLEN'(BLOCK_BYTES - 1);
    assign req_base       = pc_q & block_mask;
    assign imem_req_addr  = req_base;
    assign free_cnt       = CNT_W'(FQ_DEPTH) - count_q;

    // Only ask for a block when the whole block is guaranteed to fit; this
    // is what keeps the queue from ever overflowing.
    assign imem_req_valid = rst_n && (state_q == ST_REQ) &&
                            (free_cnt >= CNT_W'(FETCH_WIDTH));
    assign req_fire       = imem_req_valid && imem_req_ready;

    // ------------------------------------------------------------------
    // Response / enqueue side
    // ------------------------------------------------------------------
    assign resp_take  = imem_resp_valid && (state_q == ST_WAIT) && !flush;
    assign wait_base  = wait_pc_q & block_mask;
    // Lane of the first wanted word: a redirect into the middle of a block
    // drops the words before it.
    assign start_lane = LANE_W'((wait_pc_q >> 2) & XLEN'(FETCH_WIDTH - 1));
    assign enq_num    = CNT_W'(FETCH_WIDTH) - CNT_W'(start_lane);

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_slot[i] = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_en[i]   = resp_take && (LANE_W'(i) >= start_lane);
            // Kept lanes are packed contiguously starting at the write pointer.
            lane_slot[i] = wr_ptr_q + PTR_W'(i) - PTR_W'(start_lane);
        end
    end

    // ------------------------------------------------------------------
    // Dequeue side
    // ------------------------------------------------------------------
    assign deq_valid = (count_q != '0);
    assign deq_fire  = deq_valid && deq_ready && !flush;
    assign deq_pc    = pc_mem[rd_ptr_q];
    assign deq_instr = instr_mem[rd_ptr_q];
    assign fq_count  = count_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                // A flushed-but-accepted request still owes us a response,
                // which must be thrown away.
                if (req_fire) begin
                    state_d = flush ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // Further flushes here only move pc; the stale response is
                // still outstanding.
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // PC tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            wait_pc_q <= RESET_PC;
        end else begin
            if (req_fire) begin
                wait_pc_q <= pc_q;
            end
            if (flush) begin
                pc_q <= flush_pc;
            end else if (req_fire) begin
                pc_q <= pred_valid ? pred_pc : (req_base + XLEN'(BLOCK_BYTES));
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (resp_take) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(enq_num);
            end
            if (deq_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (resp_take ? enq_num : '0) - CNT_W'(deq_fire);
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (lane_en[i]) begin
                pc_mem[lane_slot[i]]    <= wait_base + XLEN'(4 * i);
                instr_mem[lane_slot[i]] <= imem_resp_data[32*i +: 32];
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Decode starvation counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_starve_cycles <= '0;
        end else if (deq_ready && !deq_valid && (perf_starve_cycles != '1)) begin
            perf_starve_cycles <= perf_starve_cycles + 32'd1;
        end
    end
`endif

endmodule
